// File: rtl/mips_pkg.sv
// Shared MIPS register-file widths and the writeback arbiter state encoding.
// Used by the writeback arbiter and its busy scoreboard.
package mips_pkg;
    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } arb_state_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy vector marking GPRs with a pending mult/div write.
// Latency: set/clear visible on queries one cycle later; no backpressure, always accepts.
// r0 is never marked busy; a set and clear of the same register in one cycle leaves it set.
module reg_scoreboard
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [REG_W-1:0] set_reg,
    input  logic             clr_en,
    input  logic [REG_W-1:0] clr_reg,
    input  logic [REG_W-1:0] rs_addr,
    input  logic [REG_W-1:0] rt_addr,
    input  logic [REG_W-1:0] rd_addr,
    output logic             rs_busy,
    output logic             rt_busy,
    output logic             rd_busy
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en && set_reg != REG_ZERO)
            set_mask[set_reg] = 1'b1;
        if (clr_en)
            clr_mask[clr_reg] = 1'b1;
        // Set is applied after clear so a same-register issue wins.
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign rs_busy = busy_q[rs_addr];
    assign rt_busy = busy_q[rt_addr];
    assign rd_busy = busy_q[rd_addr];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline WB and the mult/div result path.
// Latency: WB and bypassed results reach the port combinationally; a held result within STARVE_LIMIT+1 cycles.
// Backpressure: md_ready drops while a result is held; wb_stall only when a starved result is forced out.
module regfile_wb_arbiter
    import mips_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_stall,
    input  logic              md_issue,
    input  logic [REG_W-1:0]  md_issue_reg,
    input  logic              md_valid,
    input  logic [REG_W-1:0]  md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    input  logic [REG_W-1:0]  rs_addr,
    input  logic [REG_W-1:0]  rt_addr,
    input  logic [REG_W-1:0]  rd_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              rd_busy,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REG_W-1:0]  buf_reg_q;
    logic [DATA_W-1:0] buf_data_q;
    logic              buf_load;
    logic              md_clr;
    logic [REG_W-1:0]  md_clr_reg;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_load   = 1'b0;
        md_ready   = 1'b0;
        wb_stall   = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = wb_reg;
        rf_wdata   = wb_data;
        md_clr     = 1'b0;
        md_clr_reg = md_reg;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    md_ready = 1'b1;
                    if (wb_valid) begin
                        rf_we = (wb_reg != REG_ZERO);
                        if (md_valid) begin
                            buf_load = 1'b1;
                            cnt_d    = '0;
                            state_d  = HELD;
                        end
                    end else if (md_valid) begin
                        rf_we    = (md_reg != REG_ZERO);
                        rf_waddr = md_reg;
                        rf_wdata = md_data;
                        md_clr   = 1'b1;
                    end
                end
                HELD: begin
                    if (wb_valid && cnt_q < CNT_MAX) begin
                        rf_we = (wb_reg != REG_ZERO);
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        // Port free, or the held result has waited long enough: drain it.
                        rf_we      = (buf_reg_q != REG_ZERO);
                        rf_waddr   = buf_reg_q;
                        rf_wdata   = buf_data_q;
                        md_clr     = 1'b1;
                        md_clr_reg = buf_reg_q;
                        wb_stall   = wb_valid;
                        state_d    = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_reg_q  <= '0;
            buf_data_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (buf_load) begin
                buf_reg_q  <= md_reg;
                buf_data_q <= md_data;
            end
        end
    end

    reg_scoreboard u_scoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (md_issue),
        .set_reg (md_issue_reg),
        .clr_en  (md_clr),
        .clr_reg (md_clr_reg),
        .rs_addr (rs_addr),
        .rt_addr (rt_addr),
        .rd_addr (rd_addr),
        .rs_busy (rs_busy),
        .rt_busy (rt_busy),
        .rd_busy (rd_busy)
    );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with STARVE_LIMIT=4.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        md_issue;
    logic [4:0]  md_issue_reg;
    logic        md_valid;
    logic [4:0]  md_reg;
    logic [31:0] md_data;
    logic        md_ready;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        rs_busy, rt_busy, rd_busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_stall(wb_stall),
        .md_issue(md_issue), .md_issue_reg(md_issue_reg),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .rs_busy(rs_busy), .rt_busy(rt_busy), .rd_busy(rd_busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    task automatic quiet();
        wb_valid = 0; wb_reg = 0; wb_data = 0;
        md_issue = 0; md_issue_reg = 0;
        md_valid = 0; md_reg = 0; md_data = 0;
    endtask

    // Advance past the next rising edge; inputs are then changed away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 0; wb_valid = 1; wb_reg = 5'd4; wb_data = 32'h44;
        for (int c = 0; c < 2; c++) begin
            tick(); #1;
            total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
            total++; if (md_ready !== 1'b0) begin bad++; $display("FAIL reset_md_ready got=%b exp=0", md_ready); end
            total++; if (wb_stall !== 1'b0) begin bad++; $display("FAIL reset_wb_stall got=%b exp=0", wb_stall); end
        end
        rst_n = 1; quiet();
        tick();
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a); #1;
            total++; if (rs_busy !== 1'b0) begin bad++; $display("FAIL reset_busy r%0d got=%b exp=0", a, rs_busy); end
        end
        total++; if (md_ready !== 1'b1) begin bad++; $display("FAIL post_reset_md_ready got=%b exp=1", md_ready); end
    endtask

    task automatic test_bypass();
        quiet();
        md_issue = 1; md_issue_reg = 5'd5;
        tick();
        md_issue = 0; rs_addr = 5'd5; #1;
        total++; if (rs_busy !== 1'b1) begin bad++; $display("FAIL bypass_busy_set got=%b exp=1", rs_busy); end
        md_valid = 1; md_reg = 5'd5; md_data = 32'hDEADBEEF; #1;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL bypass_rf_we got=%b exp=1", rf_we); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL bypass_waddr got=%0d exp=5", rf_waddr); end
        total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL bypass_wdata got=%h exp=deadbeef", rf_wdata); end
        total++; if (md_ready !== 1'b1) begin bad++; $display("FAIL bypass_md_ready got=%b exp=1", md_ready); end
        tick();
        quiet(); #1;
        total++; if (rs_busy !== 1'b0) begin bad++; $display("FAIL bypass_busy_clr got=%b exp=0", rs_busy); end
        total++; if (md_ready !== 1'b1) begin bad++; $display("FAIL bypass_stay_idle got=%b exp=1", md_ready); end
    endtask

    task automatic test_collision();
        quiet();
        wb_valid = 1; wb_reg = 5'd3; wb_data = 32'h1;
        md_valid = 1; md_reg = 5'd7; md_data = 32'h2; #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h1)
            begin bad++; $display("FAIL coll_wb_write got=%b/%0d/%h exp=1/3/1", rf_we, rf_waddr, rf_wdata); end
        total++; if (md_ready !== 1'b1 || wb_stall !== 1'b0)
            begin bad++; $display("FAIL coll_hs got rdy=%b stall=%b exp=1/0", md_ready, wb_stall); end
        tick();
        quiet(); #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h2)
            begin bad++; $display("FAIL coll_buf_write got=%b/%0d/%h exp=1/7/2", rf_we, rf_waddr, rf_wdata); end
        total++; if (md_ready !== 1'b0) begin bad++; $display("FAIL coll_held_rdy got=%b exp=0", md_ready); end
        tick(); #1;
        total++; if (md_ready !== 1'b1 || rf_we !== 1'b0)
            begin bad++; $display("FAIL coll_back_idle got rdy=%b we=%b exp=1/0", md_ready, rf_we); end
    endtask

    task automatic test_starvation();
        quiet();
        md_issue = 1; md_issue_reg = 5'd12;
        tick();
        quiet(); rs_addr = 5'd12;
        wb_valid = 1; wb_reg = 5'd10; wb_data = 32'h100;
        md_valid = 1; md_reg = 5'd12; md_data = 32'hCAFE; #1;
        total++; if (rf_waddr !== 5'd10 || wb_stall !== 1'b0)
            begin bad++; $display("FAIL starve_coll got=%0d stall=%b exp=10/0", rf_waddr, wb_stall); end
        tick();
        md_valid = 0;
        for (int i = 0; i < 4; i++) begin
            wb_reg = 5'(16 + i); wb_data = 32'(i + 32'hA0); #1;
            total++; if (rf_we !== 1'b1 || rf_waddr !== 5'(16 + i) || wb_stall !== 1'b0 || md_ready !== 1'b0)
                begin bad++; $display("FAIL starve_wb%0d got we=%b addr=%0d stall=%b rdy=%b exp=1/%0d/0/0",
                                      i, rf_we, rf_waddr, wb_stall, md_ready, 16 + i); end
            tick();
        end
        wb_reg = 5'd25; wb_data = 32'h55; #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hCAFE)
            begin bad++; $display("FAIL starve_forced got=%b/%0d/%h exp=1/12/cafe", rf_we, rf_waddr, rf_wdata); end
        total++; if (wb_stall !== 1'b1) begin bad++; $display("FAIL starve_stall got=%b exp=1", wb_stall); end
        total++; if (rs_busy !== 1'b1) begin bad++; $display("FAIL starve_busy_held got=%b exp=1", rs_busy); end
        tick(); #1;
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd25 || rf_wdata !== 32'h55 || wb_stall !== 1'b0)
            begin bad++; $display("FAIL starve_wb_lands got=%b/%0d/%h stall=%b exp=1/25/55/0", rf_we, rf_waddr, rf_wdata, wb_stall); end
        total++; if (rs_busy !== 1'b0 || md_ready !== 1'b1)
            begin bad++; $display("FAIL starve_after got busy=%b rdy=%b exp=0/1", rs_busy, md_ready); end
        quiet();
        tick();
    endtask

    task automatic test_scoreboard();
        quiet();
        md_issue = 1; md_issue_reg = 5'd9;
        tick();
        quiet(); rs_addr = 5'd9; rt_addr = 5'd8; #1;
        total++; if (rs_busy !== 1'b1 || rt_busy !== 1'b0)
            begin bad++; $display("FAIL sb_issue got rs=%b rt=%b exp=1/0", rs_busy, rt_busy); end
        md_issue = 1; md_issue_reg = 5'd9;
        md_valid = 1; md_reg = 5'd9; md_data = 32'h99;
        tick();
        quiet(); #1;
        total++; if (rs_busy !== 1'b1) begin bad++; $display("FAIL sb_issue_wins got=%b exp=1", rs_busy); end
        md_issue = 1; md_issue_reg = 5'd20;
        tick();
        md_issue_reg = 5'd21;
        tick();
        quiet(); rt_addr = 5'd20; rd_addr = 5'd21; #1;
        total++; if (rs_busy !== 1'b1 || rt_busy !== 1'b1 || rd_busy !== 1'b1)
            begin bad++; $display("FAIL sb_multi got %b%b%b exp=111", rs_busy, rt_busy, rd_busy); end
        md_valid = 1; md_reg = 5'd20; md_data = 32'h20;
        tick();
        quiet(); #1;
        total++; if (rs_busy !== 1'b1 || rt_busy !== 1'b0 || rd_busy !== 1'b1)
            begin bad++; $display("FAIL sb_clear_one got %b%b%b exp=101", rs_busy, rt_busy, rd_busy); end
    endtask

    task automatic test_r0();
        quiet();
        md_issue = 1; md_issue_reg = 5'd0;
        tick();
        quiet(); rd_addr = 5'd0; #1;
        total++; if (rd_busy !== 1'b0) begin bad++; $display("FAIL r0_busy got=%b exp=0", rd_busy); end
        md_valid = 1; md_reg = 5'd0; md_data = 32'h77; #1;
        total++; if (md_ready !== 1'b1 || rf_we !== 1'b0)
            begin bad++; $display("FAIL r0_md got rdy=%b we=%b exp=1/0", md_ready, rf_we); end
        tick();
        quiet(); wb_valid = 1; wb_reg = 5'd0; wb_data = 32'h88; #1;
        total++; if (rf_we !== 1'b0 || wb_stall !== 1'b0)
            begin bad++; $display("FAIL r0_wb got we=%b stall=%b exp=0/0", rf_we, wb_stall); end
        tick();
        quiet();
    endtask

    task automatic test_reset_mid_held();
        quiet();
        md_issue = 1; md_issue_reg = 5'd14;
        tick();
        quiet();
        wb_valid = 1; wb_reg = 5'd2; md_valid = 1; md_reg = 5'd14; md_data = 32'hBAD;
        tick();
        quiet(); rs_addr = 5'd14; rst_n = 0;
        tick();
        rst_n = 1; #1;
        total++; if (rs_busy !== 1'b0) begin bad++; $display("FAIL rst_held_busy got=%b exp=0", rs_busy); end
        total++; if (md_ready !== 1'b1 || rf_we !== 1'b0)
            begin bad++; $display("FAIL rst_held_drop got rdy=%b we=%b exp=1/0", md_ready, rf_we); end
    endtask

    initial begin
        quiet();
        rst_n = 0; rs_addr = 0; rt_addr = 0; rd_addr = 0;
        test_reset();
        test_bypass();
        test_collision();
        test_starvation();
        test_scoreboard();
        test_r0();
        test_reset_mid_held();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
